// File: rtl/ibpl_pkg.sv
// Shared types and limits for the interbackplane output cardlet.
package ibpl_pkg;

  typedef enum logic [1:0] {
    IBPL_PASS,
    IBPL_STRETCH,
    IBPL_INV,
    IBPL_LOW
  } ibpl_mode_t;

  localparam int unsigned IBPL_MAX_CH = 8;

endpackage

// File: rtl/ibpl_out_ch.sv
// One backplane output channel: mode mux, min-pulse stretcher and LED activity stretcher.
module ibpl_out_ch
  import ibpl_pkg::*;
#(
  parameter int unsigned STRETCH_W = 16,
  parameter int unsigned LED_HOLD  = 125000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_i,
  input  logic                 oe_i,
  input  ibpl_mode_t           mode_i,
  input  logic [STRETCH_W-1:0] min_pulse_i,
  output logic                 out_o,
  output logic                 led_act_o
);

  localparam int unsigned LedW = $clog2(LED_HOLD + 1);

  logic [STRETCH_W-1:0] cnt_q, cnt_d;
  logic [LedW-1:0]      led_cnt_q, led_cnt_d;
  logic                 in_q;
  logic                 out_q, out_d;
  logic                 act_q;
  logic                 rise;
  logic                 stretching;
  logic                 out_nxt;

  always_comb begin
    rise       = in_i & ~in_q;
    stretching = (cnt_q != '0);

    out_nxt = 1'b0;
    unique case (mode_i)
      IBPL_PASS:    out_nxt = in_i;
      IBPL_STRETCH: out_nxt = in_i | stretching;
      IBPL_INV:     out_nxt = ~in_i;
      IBPL_LOW:     out_nxt = 1'b0;
    endcase
    // A disabled channel is always low, inverted mode included.
    out_d = oe_i & out_nxt;

    cnt_d = cnt_q;
    if (!oe_i || (mode_i != IBPL_STRETCH)) begin
      cnt_d = '0;
    end else if (rise) begin
      // The high cycle itself counts toward the minimum, so load one less.
      cnt_d = (min_pulse_i == '0) ? '0 : min_pulse_i - 1'b1;
    end else if (stretching) begin
      cnt_d = cnt_q - 1'b1;
    end

    led_cnt_d = led_cnt_q;
    if (out_d != out_q) begin
      led_cnt_d = LedW'(LED_HOLD);
    end else if (led_cnt_q != '0) begin
      led_cnt_d = led_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      led_cnt_q <= '0;
      in_q      <= 1'b0;
      out_q     <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      led_cnt_q <= led_cnt_d;
      in_q      <= in_i;
      out_q     <= out_d;
      act_q     <= (led_cnt_q != '0);
    end
  end

  assign out_o     = out_q;
  assign led_act_o = act_q;

endmodule

// File: rtl/ibpl_out_stretch.sv
// Interbackplane output cardlet: NUM_CH configurable output channels, LED activity
// stretching and a filtered enable-mismatch error.
module ibpl_out_stretch
  import ibpl_pkg::*;
#(
  parameter int unsigned NUM_CH    = 6,
  parameter int unsigned STRETCH_W = 16,
  parameter int unsigned LED_HOLD  = 125000,
  parameter int unsigned ERR_FILT  = 4
) (
  input  logic                  clk,
  input  logic                  nReset,
  input  logic [NUM_CH-1:0]     internal_out,
  input  logic [NUM_CH-1:0]     output_enable,
  input  logic [NUM_CH-1:0]     input_enable,
  input  logic [2*NUM_CH-1:0]   ch_mode,
  input  logic [STRETCH_W-1:0]  min_pulse,
  output logic [NUM_CH-1:0]     diob_out,
  output logic [NUM_CH-1:0]     diob_dir,
  output logic [NUM_CH-1:0]     internal_in,
  output logic [NUM_CH-1:0]     diob_led_en,
  output logic [NUM_CH-1:0]     diob_led_act,
  output logic                  plugin_error
);

  localparam int unsigned ErrW = $clog2(ERR_FILT + 1);

  logic [ErrW-1:0]   err_cnt_q, err_cnt_d;
  logic              err_q;
  logic [NUM_CH-1:0] led_en_q;
  logic              mis;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ibpl_out_ch #(
      .STRETCH_W (STRETCH_W),
      .LED_HOLD  (LED_HOLD)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (nReset),
      .in_i        (internal_out[i]),
      .oe_i        (output_enable[i]),
      .mode_i      (ibpl_mode_t'(ch_mode[2*i +: 2])),
      .min_pulse_i (min_pulse),
      .out_o       (diob_out[i]),
      .led_act_o   (diob_led_act[i])
    );
  end

  always_comb begin
    mis = |(input_enable & ~output_enable);
    err_cnt_d = '0;
    if (mis) begin
      err_cnt_d = (err_cnt_q == ErrW'(ERR_FILT)) ? err_cnt_q : err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      led_en_q  <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      // Flag on the updated count so a cleared mismatch drops the error on the next edge.
      err_q     <= (err_cnt_d == ErrW'(ERR_FILT));
      led_en_q  <= output_enable;
    end
  end

  assign diob_dir     = '1;
  assign internal_in  = '0;
  assign diob_led_en  = led_en_q;
  assign plugin_error = err_q;

endmodule

// File: tb/tb_ibpl_out_stretch.sv
// Self-checking bench: directed literal checks plus randomized traffic against a timeline model.
module tb_ibpl_out_stretch;

  localparam int NCH  = 6;
  localparam int MW   = 2 * NCH;
  localparam int SW   = 16;
  localparam int HOLD = 10;
  localparam int FILT = 4;

  logic              clk = 1'b0;
  logic              nReset;
  logic [NCH-1:0]    internal_out, output_enable, input_enable;
  logic [MW-1:0]     ch_mode;
  logic [SW-1:0]     min_pulse;
  logic [NCH-1:0]    diob_out, diob_dir, internal_in, diob_led_en, diob_led_act;
  logic              plugin_error;

  ibpl_out_stretch #(
    .NUM_CH    (NCH),
    .STRETCH_W (SW),
    .LED_HOLD  (HOLD),
    .ERR_FILT  (FILT)
  ) dut (
    .clk           (clk),
    .nReset        (nReset),
    .internal_out  (internal_out),
    .output_enable (output_enable),
    .input_enable  (input_enable),
    .ch_mode       (ch_mode),
    .min_pulse     (min_pulse),
    .diob_out      (diob_out),
    .diob_dir      (diob_dir),
    .internal_in   (internal_in),
    .diob_led_en   (diob_led_en),
    .diob_led_act  (diob_led_act),
    .plugin_error  (plugin_error)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: each channel remembers the cycle its stretch expires and the cycle of its
  // last output change; the error filter is the length of the current mismatch run.
  int             m_cyc;
  int             m_run;
  int             m_end  [NCH];
  int             m_last [NCH];
  bit             m_prev [NCH];
  logic [NCH-1:0] m_out, m_act, m_led_en;
  logic           m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc    = 0;
    m_run    = 0;
    m_out    = '0;
    m_act    = '0;
    m_led_en = '0;
    m_err    = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_end[c]  = 0;
      m_last[c] = -1000000;
      m_prev[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit       in, oe, o;
    bit [1:0] md;
    m_cyc++;
    m_run    = (|(input_enable & ~output_enable)) ? m_run + 1 : 0;
    m_err    = (m_run >= FILT);
    m_led_en = output_enable;
    for (int c = 0; c < NCH; c++) begin
      in = internal_out[c];
      oe = output_enable[c];
      md = ch_mode[2*c +: 2];
      case (md)
        2'd0:    o = in;
        2'd1:    o = in | (m_cyc < m_end[c]);
        2'd2:    o = !in;
        default: o = 1'b0;
      endcase
      o = o & oe;
      if (!oe || md != 2'd1) m_end[c] = 0;
      else if (in && !m_prev[c]) m_end[c] = m_cyc + ((min_pulse == '0) ? 1 : int'(min_pulse));
      m_prev[c] = in;
      m_act[c]  = (m_cyc - m_last[c]) <= HOLD;
      if (o != m_out[c]) m_last[c] = m_cyc;
      m_out[c] = o;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (nReset) model_step();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("diob_out",     32'(diob_out),     32'(m_out));
      chk("diob_led_act", 32'(diob_led_act), 32'(m_act));
      chk("diob_led_en",  32'(diob_led_en),  32'(m_led_en));
      chk("plugin_error", 32'(plugin_error), 32'(m_err));
      chk("diob_dir",     32'(diob_dir),     32'h3F);
      chk("internal_in",  32'(internal_in),  32'h0);
    end
  end

  logic [31:0] rec;
  bit          mis_on;

  initial begin
    nReset        = 1'b0;
    internal_out  = '0;
    output_enable = '0;
    input_enable  = '0;
    ch_mode       = '0;
    min_pulse     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_diob_out", 32'(diob_out), 32'h0);
    chk("rst_led_act",  32'(diob_led_act), 32'h0);
    chk("rst_led_en",   32'(diob_led_en), 32'h0);
    chk("rst_error",    32'(plugin_error), 32'h0);
    nReset = 1'b1;
    chk_en = 1'b1;
    tick();
    chk("dir_const", 32'(diob_dir), 32'h3F);

    // Pass / invert / disabled
    output_enable = '1;
    internal_out  = 6'h15;
    tick();
    chk("pass", 32'(diob_out), 32'h15);
    ch_mode = 12'hAAA;
    tick();
    chk("inv", 32'(diob_out), 32'h2A);
    output_enable = '0;
    tick();
    chk("inv_disabled", 32'(diob_out), 32'h0);
    output_enable = '1;

    // Stretch: single pulse, retrigger, short min_pulse, min_pulse changed mid-pulse
    ch_mode      = 12'h555;
    min_pulse    = 16'd5;
    internal_out = '0;
    repeat (3) tick();
    rec = '0;
    for (int i = 1; i <= 10; i++) begin
      internal_out = (i == 1) ? 6'h01 : 6'h00;
      tick();
      rec[i] = diob_out[0];
    end
    chk("stretch5", rec, 32'h003E);
    rec = '0;
    for (int i = 1; i <= 12; i++) begin
      internal_out = (i == 1 || i == 4) ? 6'h01 : 6'h00;
      tick();
      rec[i] = diob_out[0];
    end
    chk("retrigger", rec, 32'h01FE);
    min_pulse = 16'd1;
    rec = '0;
    for (int i = 1; i <= 4; i++) begin
      internal_out = (i == 1) ? 6'h01 : 6'h00;
      tick();
      rec[i] = diob_out[0];
    end
    chk("min_pulse1", rec, 32'h0002);
    min_pulse = 16'd3;
    rec = '0;
    for (int i = 1; i <= 8; i++) begin
      internal_out = (i == 1) ? 6'h01 : 6'h00;
      if (i == 2) min_pulse = 16'd20;
      tick();
      rec[i] = diob_out[0];
    end
    chk("min_pulse_latched", rec, 32'h000E);

    // LED hold on ch2
    ch_mode      = '0;
    internal_out = '0;
    repeat (14) tick();
    rec = '0;
    internal_out = 6'h04;
    for (int i = 0; i <= 14; i++) begin
      tick();
      rec[i] = diob_led_act[2];
    end
    chk("led_hold", rec, 32'h07FE);

    // Error filter on ch3
    internal_out  = '0;
    output_enable = 6'h37;
    rec = '0;
    for (int i = 1; i <= 4; i++) begin
      input_enable = (i <= 3) ? 6'h08 : 6'h00;
      tick();
      rec[i] = plugin_error;
    end
    chk("err_short", rec, 32'h0);
    rec = '0;
    for (int i = 1; i <= 9; i++) begin
      input_enable = (i <= 6) ? 6'h08 : 6'h00;
      tick();
      rec[i] = plugin_error;
    end
    chk("err_long", rec, 32'h0070);
    output_enable = '1;
    input_enable  = '0;

    // STRETCH -> LOW mid-pulse, then back without a new rise
    ch_mode      = 12'h555;
    min_pulse    = 16'd100;
    internal_out = 6'h02;
    tick();
    internal_out = '0;
    repeat (3) tick();
    chk("long_stretch", 32'(diob_out[1]), 32'h1);
    ch_mode[3:2] = 2'b11;
    tick();
    chk("to_low", 32'(diob_out[1]), 32'h0);
    ch_mode[3:2] = 2'b01;
    rec = '0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      rec[i] = diob_out[1];
    end
    chk("back_to_stretch", rec, 32'h0);

    // Asynchronous reset in the middle of a stretch
    min_pulse    = 16'd10;
    internal_out = 6'h01;
    tick();
    internal_out = '0;
    repeat (2) tick();
    chk("pre_reset_high", 32'(diob_out[0]), 32'h1);
    #2;
    nReset = 1'b0;
    model_reset();
    #1;
    chk("async_rst_out", 32'(diob_out), 32'h0);
    chk("async_rst_act", 32'(diob_led_act), 32'h0);
    chk("async_rst_en",  32'(diob_led_en), 32'h0);
    @(negedge clk);
    nReset = 1'b1;
    tick();
    chk("post_rst_dir", 32'(diob_dir), 32'h3F);
    chk("post_rst_in",  32'(internal_in), 32'h0);
    chk("post_rst_out", 32'(diob_out), 32'h0);

    // Randomized traffic
    mis_on = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) ch_mode = MW'($urandom);
      if ($urandom_range(0, 31) == 0) output_enable = NCH'($urandom) | NCH'($urandom);
      if ($urandom_range(0, 9) == 0) mis_on = !mis_on;
      input_enable = mis_on ? (output_enable | NCH'($urandom)) : (output_enable & NCH'($urandom));
      internal_out = internal_out ^ (NCH'($urandom) & NCH'($urandom) & NCH'($urandom));
      if ($urandom_range(0, 7) == 0) min_pulse = SW'($urandom_range(0, 12));
      tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
